hdmi_timing_gen: RTL and testbench
==================================

HDMI_TIMING_GEN -- requirements
Module: hdmi_timing_gen

Interface
REQ-001 SHALL have parameter CLK_DIV, default 5: clk cycles per pixel period.
REQ-002 SHALL have parameters H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal timing in pixels.
REQ-003 SHALL have parameters V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical timing in lines.
REQ-004 SHALL have parameter MEM_LINES, default 400: active lines backed by the frame memory (640x400 = 256000 pixels).
REQ-005 SHALL have port clk  in  1: the single system clock; all logic is on its rising edge.
REQ-006 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-007 SHALL have port en  in  1: run enable; low holds the block idle.
REQ-008 SHALL have port pix_ce  out  1: one-clk pulse at the start of each pixel period.
REQ-009 SHALL have port HHsync  out  1: horizontal sync, active-low.
REQ-010 SHALL have port HVsync  out  1: vertical sync, active-low; the frame memory read address clears while it is low.
REQ-011 SHALL have port HMemRead  out  1: frame-memory read-advance request.
REQ-012 SHALL have port pVDE  out  1: active-video data enable.
REQ-013 SHALL have port pix_x  out  10: current horizontal counter value.
REQ-014 SHALL have port pix_y  out  10: current vertical counter value.
REQ-015 SHALL have port frame_start  out  1: one-clk pulse at pixel (0,0).

Function
REQ-016 SHALL run a divider counting 0..CLK_DIV-1 that wraps to 0, and SHALL assert pix_ce when the divider is 0.
REQ-017 SHALL advance h_cnt only on pix_ce, counting 0..H_TOTAL-1 (H_TOTAL = 800) and wrapping to 0.
REQ-018 SHALL advance v_cnt by one when h_cnt wraps, counting 0..V_TOTAL-1 (V_TOTAL = 525) and wrapping to 0.
REQ-019 SHALL drive HHsync low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656, 751].
REQ-020 SHALL drive HVsync low for v_cnt in [490, 491].
REQ-021 SHALL assert pVDE for h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-022 SHALL assert HMemRead only for v_cnt < MEM_LINES, and then for h_cnt < H_ACTIVE-1 and for h_cnt = H_TOTAL-1, i.e. one pixel ahead of pVDE (prefetch lead of 1).
REQ-023 SHALL deassert HMemRead on lines MEM_LINES..V_ACTIVE-1 while pVDE stays asserted (the downstream stage blanks those lines).
REQ-024 SHALL register all outputs and update them in the same clk as the counter change, giving a latency of 1 clk from the counter to the outputs.
REQ-025 SHALL assert frame_start for exactly one clk when h_cnt = 0 and v_cnt = 0, coincident with pix_ce.
REQ-026 SHALL, while en is low: clear the divider and counters to 0, hold HHsync and HVsync high, hold pVDE, HMemRead, pix_ce and frame_start low, and produce no pulses.
REQ-027 SHALL, on the rise of en, issue the first pix_ce on the next clk with pixel (0,0), which also produces frame_start.
REQ-028 SHALL use counter widths that cover 1023, and SHALL support any parameter set with totals <= 1024.

Reset
REQ-029 SHALL, on rst high at a clk edge, set the divider, h_cnt, v_cnt, pix_x and pix_y to 0.
REQ-030 SHALL, on rst high at a clk edge, set HHsync and HVsync to 1, and set pix_ce, pVDE, HMemRead and frame_start to 0.
REQ-031 SHALL treat rst asserted mid-frame the same as reset from power-up, and SHALL give rst priority over en.
REQ-032 SHALL restart from pixel (0,0) on the first clk after rst falls, provided en is high.

Structure
REQ-033 SHALL place the default 640x480 timing constants, MEM_LINES and CLK_DIV in a shared package video_timing_pkg, used by both this block and the memory block.
REQ-034 SHALL use one sub-module, sync_counter: a parameterised wrap counter with a sync-window compare, instantiated once for horizontal and once for vertical.

Verification
REQ-035 Reset then en=1: pix_ce period is 5 clk, and frame_start recurs every 800*525*5 = 2,100,000 clk.
REQ-036 Line 0: pVDE is high for 640 pix_ce and low for 160; HHsync is low for exactly 96 pix_ce, starting at h_cnt 656.
REQ-037 Frame: HVsync is low on lines 490-491 only, and pVDE is high on 480 lines.
REQ-038 HMemRead count: 640 per line on lines 0-399, 0 on lines 400-524, and 256000 per frame.
REQ-039 Assert rst at v_cnt 200, h_cnt 300 for 3 clk: all outputs take reset values, and the first pix_ce after release is at (0,0) with frame_start.
REQ-040 Drop en for 10 clk mid-line: outputs idle as in REQ-026, and on re-enable the next frame_start occurs 1 clk later.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared 640x480@60 video timing constants and helpers used by the timing
// generator and the frame memory block.
package video_timing_pkg;

    localparam int CNT_W = 10;

    localparam int DEF_CLK_DIV   = 5;
    localparam int DEF_H_ACTIVE  = 640;
    localparam int DEF_H_FP      = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BP      = 48;
    localparam int DEF_V_ACTIVE  = 480;
    localparam int DEF_V_FP      = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BP      = 33;
    localparam int DEF_MEM_LINES = 400;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef logic [CNT_W-1:0] cnt_t;

    // Inclusive window test shared by the horizontal and vertical sync decode.
    function automatic logic in_window(input cnt_t value, input cnt_t lo, input cnt_t hi);
        return (value >= lo) && (value <= hi);
    endfunction

endpackage

// File: rtl/sync_counter.sv
// Wrap counter 0..TOTAL-1 with a combinational sync-window decode; used once
// for pixels within a line and once for lines within a frame.
module sync_counter
    import video_timing_pkg::*;
#(
    parameter int TOTAL      = DEF_H_TOTAL,
    parameter int SYNC_START = DEF_H_ACTIVE + DEF_H_FP,
    parameter int SYNC_END   = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             wrap,
    output logic             in_sync
);

    localparam cnt_t LAST = cnt_t'(TOTAL - 1);
    localparam cnt_t S_LO = cnt_t'(SYNC_START);
    localparam cnt_t S_HI = cnt_t'(SYNC_END);

    assign wrap    = inc && (cnt == LAST);
    assign in_sync = in_window(cnt, S_LO, S_HI);

    // NOTE: sequential state is assigned with <= so every reader in the same
    // edge sees the pre-edge count; blocking here would create order races.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + cnt_t'(1);
        end
    end

endmodule

// File: rtl/hdmi_timing_gen.sv
// Pixel-clock-enable based video timing generator: divider, h/v counters and
// registered sync, data-enable and frame-memory prefetch strobes.
module hdmi_timing_gen
    import video_timing_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter int MEM_LINES = DEF_MEM_LINES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             pix_ce,
    output logic             HHsync,
    output logic             HVsync,
    output logic             HMemRead,
    output logic             pVDE,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam cnt_t HA_C    = cnt_t'(H_ACTIVE);
    localparam cnt_t HA_M1   = cnt_t'(H_ACTIVE - 1);
    localparam cnt_t HT_M1   = cnt_t'(H_TOTAL - 1);
    localparam cnt_t VA_C    = cnt_t'(V_ACTIVE);
    localparam cnt_t MEM_L_C = cnt_t'(MEM_LINES);

    logic [DIV_W-1:0] div;
    logic             tick;
    cnt_t             h_cnt;
    cnt_t             v_cnt;
    logic             h_wrap;
    logic             v_wrap;
    logic             h_sync;
    logic             v_sync;
    logic             vde_next;
    logic             mem_read_next;

    assign tick = (div == '0);

    sync_counter #(
        .TOTAL      (H_TOTAL),
        .SYNC_START (H_ACTIVE + H_FP),
        .SYNC_END   (H_ACTIVE + H_FP + H_SYNC - 1)
    ) u_h_counter (
        .clk     (clk),
        .rst     (rst),
        .clr     (!en),
        .inc     (tick),
        .cnt     (h_cnt),
        .wrap    (h_wrap),
        .in_sync (h_sync)
    );

    sync_counter #(
        .TOTAL      (V_TOTAL),
        .SYNC_START (V_ACTIVE + V_FP),
        .SYNC_END   (V_ACTIVE + V_FP + V_SYNC - 1)
    ) u_v_counter (
        .clk     (clk),
        .rst     (rst),
        .clr     (!en),
        .inc     (h_wrap),
        .cnt     (v_cnt),
        .wrap    (v_wrap),
        .in_sync (v_sync)
    );

    // Memory read leads pVDE by one pixel, including the last pixel of the
    // previous line; lines past MEM_LINES are not backed by memory.
    assign vde_next      = (h_cnt < HA_C) && (v_cnt < VA_C);
    assign mem_read_next = (v_cnt < MEM_L_C) && ((h_cnt < HA_M1) || (h_cnt == HT_M1));

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            div         <= '0;
            pix_ce      <= 1'b0;
            HHsync      <= 1'b1;
            HVsync      <= 1'b1;
            HMemRead    <= 1'b0;
            pVDE        <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            frame_start <= 1'b0;
        end else begin
            div         <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
            pix_ce      <= tick;
            frame_start <= tick && (h_cnt == '0) && (v_cnt == '0);
            if (tick) begin
                HHsync   <= !h_sync;
                HVsync   <= !v_sync;
                HMemRead <= mem_read_next;
                pVDE     <= vde_next;
                pix_x    <= h_cnt;
                pix_y    <= v_cnt;
            end
        end
    end

endmodule

// File: tb/tb_hdmi_timing_gen.sv
// Self-checking bench: a small-raster instance and a default 640x480 instance
// checked every cycle against a pixel-index model plus literal frame/line counts.
module tb_hdmi_timing_gen;

    typedef struct packed {
        logic       ce;
        logic       hs;
        logic       vs;
        logic       mr;
        logic       de;
        logic       fs;
        logic [9:0] x;
        logic [9:0] y;
    } vout_t;

    localparam vout_t IDLE = '{ce: 1'b0, hs: 1'b1, vs: 1'b1, mr: 1'b0, de: 1'b0,
                               fs: 1'b0, x: 10'd0, y: 10'd0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b1;

    always #5 clk = ~clk;

    logic       s_ce, s_hs, s_vs, s_mr, s_de, s_fs;
    logic [9:0] s_x, s_y;
    logic       d_ce, d_hs, d_vs, d_mr, d_de, d_fs;
    logic [9:0] d_x, d_y;

    hdmi_timing_gen #(
        .CLK_DIV(5), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .MEM_LINES(8)
    ) u_small (
        .clk(clk), .rst(rst), .en(en), .pix_ce(s_ce), .HHsync(s_hs), .HVsync(s_vs),
        .HMemRead(s_mr), .pVDE(s_de), .pix_x(s_x), .pix_y(s_y), .frame_start(s_fs)
    );

    hdmi_timing_gen u_dflt (
        .clk(clk), .rst(rst), .en(en), .pix_ce(d_ce), .HHsync(d_hs), .HVsync(d_vs),
        .HMemRead(d_mr), .pVDE(d_de), .pix_x(d_x), .pix_y(d_y), .frame_start(d_fs)
    );

    vout_t s_act, d_act;
    assign s_act = '{ce: s_ce, hs: s_hs, vs: s_vs, mr: s_mr, de: s_de, fs: s_fs, x: s_x, y: s_y};
    assign d_act = '{ce: d_ce, hs: d_hs, vs: d_vs, mr: d_mr, de: d_de, fs: d_fs, x: d_x, y: d_y};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output of a running raster t clocks after start: pixel index t/div,
    // position within the raster by plain division, then the timing rules.
    function automatic vout_t model(input longint t, input int div,
                                    input int ha, input int hfp, input int hsw, input int hbp,
                                    input int va, input int vfp, input int vsw, input int vbp,
                                    input int ml);
        vout_t  o;
        longint p;
        int     ht, vt, x, y;
        o = IDLE;
        if (t < 0) return o;
        ht = ha + hfp + hsw + hbp;
        vt = va + vfp + vsw + vbp;
        p  = t / div;
        x  = int'(p % ht);
        y  = int'((p / ht) % vt);
        o.ce = ((t % div) == 0);
        o.hs = !((x >= ha + hfp) && (x < ha + hfp + hsw));
        o.vs = !((y >= va + vfp) && (y < va + vfp + vsw));
        o.de = (x < ha) && (y < va);
        o.mr = (y < ml) && ((x < ha - 1) || (x == ht - 1));
        o.fs = o.ce && (x == 0) && (y == 0);
        o.x  = 10'(x);
        o.y  = 10'(y);
        return o;
    endfunction

    // Clocks since the raster (re)started; -1 while held in reset or disabled.
    longint t = -1;
    always @(posedge clk) t <= (rst || !en) ? -1 : t + 1;

    bit    chk_on = 1'b0;
    vout_t s_exp, d_exp;

    int ce_gap, f_clk, f_mr, f_de, f_vs, frames_checked;
    bit ce_seen, f_full;
    int d_pix, d_de_n, d_hs_n, d_mr_n, d_first;
    bit d_done = 1'b0;

    always @(negedge clk) begin
        if (chk_on) begin
            s_exp = model(t, 5, 16, 2, 4, 3, 12, 2, 2, 3, 8);
            d_exp = model(t, 5, 640, 16, 96, 48, 480, 10, 2, 33, 400);
            check("small_cycle", 32'(s_act), 32'(s_exp));
            check("default_cycle", 32'(d_act), 32'(d_exp));

            if (t < 0) begin
                ce_seen = 1'b0; f_full = 1'b0; ce_gap = 0;
                d_pix = 0; d_de_n = 0; d_hs_n = 0; d_mr_n = 0; d_first = -1;
            end else begin
                ce_gap++;
                if (s_ce) begin
                    if (ce_seen) check("pix_ce_period", 32'(ce_gap), 32'd5);
                    ce_seen = 1'b1;
                    ce_gap  = 0;
                end
                if (s_fs) begin
                    if (f_full) begin
                        check("frame_clks", 32'(f_clk), 32'd2375);
                        check("frame_memread", 32'(f_mr), 32'd128);
                        check("frame_vde", 32'(f_de), 32'd192);
                        check("frame_vsync_low", 32'(f_vs), 32'd50);
                        frames_checked++;
                    end
                    f_full = 1'b1;
                    f_clk = 0; f_mr = 0; f_de = 0; f_vs = 0;
                end
                f_clk++;
                if (s_ce) begin
                    f_mr += int'(s_mr);
                    f_de += int'(s_de);
                    f_vs += int'(!s_vs);
                end
                if (d_ce && !d_done) begin
                    if (!d_hs && d_first < 0) d_first = int'(d_x);
                    d_de_n += int'(d_de);
                    d_hs_n += int'(!d_hs);
                    d_mr_n += int'(d_mr);
                    d_pix++;
                    if (d_pix == 800) begin
                        check("line0_vde", 32'(d_de_n), 32'd640);
                        check("line0_hsync_low", 32'(d_hs_n), 32'd96);
                        check("line0_hsync_first_x", 32'(d_first), 32'd656);
                        check("line0_memread", 32'(d_mr_n), 32'd640);
                        d_done = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        frames_checked = 0;
        rst = 1'b1;
        en  = 1'b1;
        repeat (2) @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk);
        check("reset_state", 32'(s_act), 32'(IDLE));

        // Release reset: pixel (0,0) with frame_start on the very next clk.
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("first_after_reset", 32'({s_ce, s_fs, s_x, s_y}), {10'd0, 1'b1, 1'b1, 10'd0, 10'd0});

        // Two full small frames and the whole first default line, then a
        // mid-frame reset held for three clocks.
        repeat (5425) @(posedge clk);
        #1 rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("midframe_reset", 32'(s_act), 32'(IDLE));
            check("midframe_reset_dflt", 32'(d_act), 32'(IDLE));
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("restart_after_reset", 32'({s_ce, s_fs, s_x, s_y}), {10'd0, 1'b1, 1'b1, 10'd0, 10'd0});

        // Enable drop mid-line for 10 clocks.
        repeat (300) @(posedge clk);
        #1 en = 1'b0;
        repeat (10) begin
            @(posedge clk);
            @(negedge clk);
            check("en_low_idle", 32'(s_act), 32'(IDLE));
        end
        en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reenable_frame_start", 32'({s_ce, s_fs, s_x, s_y}), {10'd0, 1'b1, 1'b1, 10'd0, 10'd0});

        repeat (2 * 2375 + 10) @(posedge clk);
        @(negedge clk);
        check("line0_stats_seen", 32'(d_done), 32'd1);
        check("frames_seen", 32'(frames_checked >= 3), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
